id_ex_hazard_stage: RTL

- Pipeline register between decode and execute.
- Latches the Main_Control outputs and the decoded operands.
- Detects load-use hazards and drives the Stall fed back to Main_Control and the IF/ID register.
- Registers per-operand forwarding selects for the EX-stage muxes and keeps a saturating stall counter.

---
 rtl/id_ex_hazard_stage_if.sv | 56 +++++
 rtl/id_ex_hazard_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_hazard_stage_if.sv
// ID/EX stage bus.
// Groups everything that passes between decode, the ID/EX register and execute:
//   id_*            decoded instruction presented by the ID stage
//   flush           squash of the ID instruction (redirect)
//   mem_rd/regwrite destination of the instruction currently in MEM
//   stall           load-use stall fed back to Main_Control and IF/ID
//   ex_*            latched instruction seen by the EX stage
//   stall_cnt       saturating count of stall cycles
// The master drives the ID side and reads the EX side; the slave is the
// ID/EX register itself.
interface id_ex_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [4:0]        id_opcode;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic [8:0]        id_ctrl;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [DATA_W-1:0] id_imm;
  logic [DATA_W-1:0] id_pc;
  logic              flush;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;

  logic              stall;
  logic              ex_valid;
  logic [4:0]        ex_opcode;
  logic [8:0]        ex_ctrl;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] ex_imm;
  logic [DATA_W-1:0] ex_pc;
  logic [1:0]        ex_fwd_a;
  logic [1:0]        ex_fwd_b;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_ctrl,
           id_a, id_b, id_imm, id_pc, flush, mem_rd, mem_regwrite,
    input  stall, ex_valid, ex_opcode, ex_ctrl, ex_rd, ex_a, ex_b,
           ex_imm, ex_pc, ex_fwd_a, ex_fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, id_ctrl,
           id_a, id_b, id_imm, id_pc, flush, mem_rd, mem_regwrite,
    output stall, ex_valid, ex_opcode, ex_ctrl, ex_rd, ex_a, ex_b,
           ex_imm, ex_pc, ex_fwd_a, ex_fwd_b, stall_cnt
  );
endinterface

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// Latches Main_Control outputs and decoded operands for the EX stage, raises
// a combinational stall on a load-use dependency (inserting a bubble), and
// registers per-operand forwarding selects for the EX muxes:
//   00 register file, 01 EX/MEM result, 10 MEM/WB result.
// A saturating counter tracks the number of stall cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    id_ex_hazard_stage_if slave: ID inputs, flush, MEM destination,
//          stall and all ex_* outputs, stall_cnt
// id_ctrl / ex_ctrl layout:
//   [8] ExtOp [7] RegWrite [6] ALUSrc [5] MemRd [4] MemWr [3] RegSel
//   [2:1] WB  [0] RegR2
module id_ex_hazard_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 3,
  parameter int LINK_REG = 7,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  id_ex_hazard_stage_if.slave bus
);

  localparam int CB_REGWRITE = 7;
  localparam int CB_MEMRD    = 5;
  localparam int CB_REGSEL   = 3;

  localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);

  logic              r_ex_valid;
  logic [4:0]        r_ex_opcode;
  logic [8:0]        r_ex_ctrl;
  logic [REG_AW-1:0] r_ex_rd;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [DATA_W-1:0] r_ex_imm;
  logic [DATA_W-1:0] r_ex_pc;
  logic [1:0]        r_ex_fwd_a;
  logic [1:0]        r_ex_fwd_b;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_hit_rs1;
  logic              w_hit_rs2;
  logic              w_stall;
  logic [8:0]        w_ctrl;
  logic [REG_AW-1:0] w_rd;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  function automatic logic uses_rs1(input logic [4:0] op);
    return (op <= 5'd10) || (op == 5'd13);
  endfunction

  function automatic logic uses_rs2(input logic [4:0] op);
    return (op <= 5'd4) || (op == 5'd10);
  endfunction

  // Forwarding select from the state before the edge. A load in EX is never
  // a 01 source: its data is not ready, that case is a stall instead.
  function automatic logic [1:0] fwd_sel(
    input logic              used,
    input logic [REG_AW-1:0] src,
    input logic              ex_v,
    input logic [8:0]        ex_c,
    input logic [REG_AW-1:0] ex_r,
    input logic              m_wr,
    input logic [REG_AW-1:0] m_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != '0)) begin
      if (ex_v && ex_c[CB_REGWRITE] && !ex_c[CB_MEMRD] && (ex_r == src))
        sel = 2'b01;
      else if (m_wr && (m_rd == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  assign w_use_rs1 = uses_rs1(bus.id_opcode);
  assign w_use_rs2 = uses_rs2(bus.id_opcode);
  assign w_hit_rs1 = w_use_rs1 && (bus.id_rs1 == r_ex_rd);
  assign w_hit_rs2 = w_use_rs2 && (bus.id_rs2 == r_ex_rd);

  // Depends on registered EX state, so it reads 0 while held in reset.
  assign w_stall = bus.id_valid && !bus.flush && r_ex_valid &&
                   r_ex_ctrl[CB_MEMRD] && (r_ex_rd != '0) &&
                   (w_hit_rs1 || w_hit_rs2);

  // Invalid slots carry no control so they can never write or touch memory.
  assign w_ctrl = bus.id_valid ? bus.id_ctrl : 9'd0;

  // Non-writers get rd=0 so they can never be matched as a forwarding source.
  assign w_rd = !w_ctrl[CB_REGWRITE] ? '0 :
                (w_ctrl[CB_REGSEL] ? LINK_IDX : bus.id_rd);

  assign w_fwd_a = fwd_sel(w_use_rs1, bus.id_rs1, r_ex_valid, r_ex_ctrl,
                           r_ex_rd, bus.mem_regwrite, bus.mem_rd);
  assign w_fwd_b = fwd_sel(w_use_rs2, bus.id_rs2, r_ex_valid, r_ex_ctrl,
                           r_ex_rd, bus.mem_regwrite, bus.mem_rd);

  // ID -> EX register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_opcode <= '0;
      r_ex_ctrl   <= '0;
      r_ex_rd     <= '0;
      r_ex_a      <= '0;
      r_ex_b      <= '0;
      r_ex_imm    <= '0;
      r_ex_pc     <= '0;
      r_ex_fwd_a  <= '0;
      r_ex_fwd_b  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.flush || w_stall) begin
        // Bubble: on a stall the ID instruction is held upstream and
        // re-presented next cycle, when the load has moved to MEM.
        r_ex_valid  <= 1'b0;
        r_ex_opcode <= '0;
        r_ex_ctrl   <= '0;
        r_ex_rd     <= '0;
        r_ex_a      <= '0;
        r_ex_b      <= '0;
        r_ex_imm    <= '0;
        r_ex_pc     <= '0;
        r_ex_fwd_a  <= '0;
        r_ex_fwd_b  <= '0;
      end else begin
        r_ex_valid  <= bus.id_valid;
        r_ex_opcode <= bus.id_opcode;
        r_ex_ctrl   <= w_ctrl;
        r_ex_rd     <= w_rd;
        r_ex_a      <= bus.id_a;
        r_ex_b      <= bus.id_b;
        r_ex_imm    <= bus.id_imm;
        r_ex_pc     <= bus.id_pc;
        r_ex_fwd_a  <= w_fwd_a;
        r_ex_fwd_b  <= w_fwd_b;
      end

      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.stall     = w_stall;
  assign bus.ex_valid  = r_ex_valid;
  assign bus.ex_opcode = r_ex_opcode;
  assign bus.ex_ctrl   = r_ex_ctrl;
  assign bus.ex_rd     = r_ex_rd;
  assign bus.ex_a      = r_ex_a;
  assign bus.ex_b      = r_ex_b;
  assign bus.ex_imm    = r_ex_imm;
  assign bus.ex_pc     = r_ex_pc;
  assign bus.ex_fwd_a  = r_ex_fwd_a;
  assign bus.ex_fwd_b  = r_ex_fwd_b;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
